// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus bundle: cache instruction-port handshake plus decoder-facing queue head.
// master = fetcher side, slave = cache/decoder side.
interface instruction_fetcher_if;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic [31:0] i_result;
  logic        i_ready;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;

  modport master (
    output i_waiting, i_addr, inst_valid, inst, inst_pc, inst_pred_taken,
    input  i_result, i_ready, dec_ready
  );

  modport slave (
    input  i_waiting, i_addr, inst_valid, inst, inst_pc, inst_pred_taken,
    output i_result, i_ready, dec_ready
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: one outstanding cache request, static JAL/backward-branch
// prediction, and a small circular instruction queue feeding the decoder.
module instruction_fetcher #(
  parameter int          QUEUE_DEPTH_BITS = 2,
  parameter logic [31:0] RESET_PC         = 32'h0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     RoB_clear,
  input  logic [31:0]              RoB_new_pc,
  instruction_fetcher_if.master    bus
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_BITS;
  localparam logic [QUEUE_DEPTH_BITS:0]   CNT_ZERO = '0;
  localparam logic [QUEUE_DEPTH_BITS:0]   CNT_ONE  = (QUEUE_DEPTH_BITS+1)'(1);
  localparam logic [QUEUE_DEPTH_BITS:0]   CNT_FULL = (QUEUE_DEPTH_BITS+1)'(DEPTH);
  localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ZERO = '0;
  localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ONE  = QUEUE_DEPTH_BITS'(1);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t                      r_state;
  logic [31:0]                 r_fetch_pc;
  logic                        r_i_waiting;
  logic [QUEUE_DEPTH_BITS:0]   r_count;
  logic [QUEUE_DEPTH_BITS-1:0] r_head;
  logic [QUEUE_DEPTH_BITS-1:0] r_tail;
  logic [31:0]                 r_q_inst [DEPTH];
  logic [31:0]                 r_q_pc   [DEPTH];
  logic                        r_q_pred [DEPTH];

  logic                        w_push;
  logic                        w_pop;
  logic [QUEUE_DEPTH_BITS:0]   w_count_next;
  logic                        w_pred_taken;
  logic [31:0]                 w_pred_next;

  function automatic logic [31:0] j_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Static prediction: JAL and backward conditional branches are taken.
  always_comb begin
    w_pred_taken = 1'b0;
    w_pred_next  = r_fetch_pc + 32'd4;
    if (bus.i_result[6:0] == OP_JAL) begin
      w_pred_taken = 1'b1;
      w_pred_next  = r_fetch_pc + j_imm(bus.i_result);
    end else if ((bus.i_result[6:0] == OP_BRANCH) && bus.i_result[31]) begin
      w_pred_taken = 1'b1;
      w_pred_next  = r_fetch_pc + b_imm(bus.i_result);
    end else begin
      w_pred_taken = 1'b0;
      w_pred_next  = r_fetch_pc + 32'd4;
    end
  end

  // Queue push/pop qualifiers and the resulting occupancy.
  always_comb begin
    w_push       = (r_state == ST_FETCH) && bus.i_ready;
    w_pop        = (r_count != CNT_ZERO) && bus.dec_ready;
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Fetch FSM, fetch PC, request flag and queue pointers/occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_i_waiting <= 1'b0;
      r_count     <= CNT_ZERO;
      r_head      <= PTR_ZERO;
      r_tail      <= PTR_ZERO;
    end else if (rdy_in) begin
      if (RoB_clear) begin
        r_state     <= ST_IDLE;
        r_fetch_pc  <= RoB_new_pc;
        r_i_waiting <= 1'b0;
        r_count     <= CNT_ZERO;
        r_head      <= PTR_ZERO;
        r_tail      <= PTR_ZERO;
      end else begin
        r_count <= w_count_next;
        if (w_push) r_tail <= r_tail + PTR_ONE;
        if (w_pop)  r_head <= r_head + PTR_ONE;
        case (r_state)
          ST_IDLE: begin
            // Entering FETCH only with a free slot guarantees the completion push fits.
            if (r_count < CNT_FULL) begin
              r_state     <= ST_FETCH;
              r_i_waiting <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (w_push) begin
              r_fetch_pc <= w_pred_next;
              if (w_count_next >= CNT_FULL) begin
                r_state     <= ST_IDLE;
                r_i_waiting <= 1'b0;
              end
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_i_waiting <= 1'b0;
          end
        endcase
      end
    end
  end

  // Queue storage, written at tail on a completed fetch.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_q_inst[k] <= 32'h0;
        r_q_pc[k]   <= 32'h0;
        r_q_pred[k] <= 1'b0;
      end
    end else if (rdy_in && !RoB_clear && w_push) begin
      r_q_inst[r_tail] <= bus.i_result;
      r_q_pc[r_tail]   <= r_fetch_pc;
      r_q_pred[r_tail] <= w_pred_taken;
    end
  end

  assign bus.i_waiting       = r_i_waiting;
  assign bus.i_addr          = r_fetch_pc;
  assign bus.inst_valid      = (r_count != CNT_ZERO);
  assign bus.inst            = r_q_inst[r_head];
  assign bus.inst_pc         = r_q_pc[r_head];
  assign bus.inst_pred_taken = r_q_pred[r_head];

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a behavioural cache and a scoreboard of
// expected queue entries checked as the decoder consumes them.
module tb_instruction_fetcher;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [31:0] rob_pc;
  logic        hit;
  logic [31:0] ov_addr;
  logic [31:0] ov_word;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  exp_t sb [$];

  instruction_fetcher_if bus ();

  instruction_fetcher #(.QUEUE_DEPTH_BITS(2), .RESET_PC(32'h0)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .RoB_clear  (rob_clear),
    .RoB_new_pc (rob_pc),
    .bus        (bus)
  );

  // Cache model: answers in the same cycle when hit is set; one overridable address.
  assign bus.i_ready  = hit && bus.i_waiting;
  assign bus.i_result = (bus.i_addr == ov_addr) ? ov_word : 32'h00000013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_taken(input logic [31:0] w);
    return (w[6:0] == 7'b1101111) || ((w[6:0] == 7'b1100011) && w[31]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    rob_clear = 1'b1;
    rob_pc    = pc;
    tick(1);
    rob_clear = 1'b0;
    chk("redir_idle_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("redir_flush_valid", {31'h0, bus.inst_valid}, 32'd0);
    tick(1);
    chk("redir_fetch_waiting", {31'h0, bus.i_waiting}, 32'd1);
    chk("redir_addr", bus.i_addr, pc);
  endtask

  // Scoreboard: sampled mid-cycle for the edge that follows.
  always @(negedge clk) begin
    if (!rst_in || (rdy_in && rob_clear)) begin
      sb.delete();
    end else if (rdy_in) begin
      if (bus.inst_valid && bus.dec_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pop_pc", bus.inst_pc, 32'hxxxxxxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_inst", bus.inst, e.word);
          chk("sb_pc", bus.inst_pc, e.pc);
          chk("sb_pred", {31'h0, bus.inst_pred_taken}, {31'h0, e.pred});
        end
      end
      if (bus.i_waiting && bus.i_ready) begin
        sb.push_back('{word: bus.i_result, pc: bus.i_addr, pred: ref_taken(bus.i_result)});
      end
    end
  end

  initial begin
    rst_in        = 1'b0;
    rdy_in        = 1'b0;
    rob_clear     = 1'b0;
    rob_pc        = 32'h0;
    hit           = 1'b0;
    ov_addr       = 32'hFFFF_FFF0;
    ov_word       = 32'h00000013;
    bus.dec_ready = 1'b0;

    tick(2);
    chk("rst_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("rst_addr", bus.i_addr, 32'h0);
    chk("rst_valid", {31'h0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_pred", {31'h0, bus.inst_pred_taken}, 32'd0);

    // First fetch after reset
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick(1);
    chk("first_waiting", {31'h0, bus.i_waiting}, 32'd1);
    chk("first_addr", bus.i_addr, 32'h0);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    chk("first_valid", {31'h0, bus.inst_valid}, 32'd1);
    chk("first_inst", bus.inst, 32'h00000013);
    chk("first_pc", bus.inst_pc, 32'h0);
    chk("first_pred", {31'h0, bus.inst_pred_taken}, 32'd0);
    chk("first_next_addr", bus.i_addr, 32'h4);
    bus.dec_ready = 1'b1;
    tick(1);
    chk("first_drained", {31'h0, bus.inst_valid}, 32'd0);

    // JAL +0x20 at 0x10
    ov_addr = 32'h10;
    ov_word = 32'h0200006F;
    redirect(32'h10);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    chk("jal_next_addr", bus.i_addr, 32'h30);
    chk("jal_pred", {31'h0, bus.inst_pred_taken}, 32'd1);
    chk("jal_pc", bus.inst_pc, 32'h10);
    tick(1);

    // Backward branch -8 at 0x40
    ov_addr = 32'h40;
    ov_word = 32'hFE000CE3;
    redirect(32'h40);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    chk("bwd_next_addr", bus.i_addr, 32'h38);
    chk("bwd_pred", {31'h0, bus.inst_pred_taken}, 32'd1);
    tick(1);

    // Forward branch +8 at 0x40
    ov_word = 32'h00000463;
    redirect(32'h40);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    chk("fwd_next_addr", bus.i_addr, 32'h44);
    chk("fwd_pred", {31'h0, bus.inst_pred_taken}, 32'd0);
    tick(1);

    // Fill the queue with the decoder stalled
    ov_addr       = 32'hFFFF_FFF0;
    bus.dec_ready = 1'b0;
    redirect(32'h200);
    hit = 1'b1;
    tick(4);
    chk("full_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("full_addr", bus.i_addr, 32'h210);
    chk("full_valid", {31'h0, bus.inst_valid}, 32'd1);
    chk("full_head_pc", bus.inst_pc, 32'h200);
    tick(2);
    chk("full_hold_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("full_hold_addr", bus.i_addr, 32'h210);
    bus.dec_ready = 1'b1;
    tick(1);
    bus.dec_ready = 1'b0;
    chk("pop_idle_waiting", {31'h0, bus.i_waiting}, 32'd0);
    tick(1);
    chk("resume_waiting", {31'h0, bus.i_waiting}, 32'd1);
    chk("resume_addr", bus.i_addr, 32'h210);
    hit           = 1'b0;
    bus.dec_ready = 1'b1;
    tick(3);
    chk("drain_valid", {31'h0, bus.inst_valid}, 32'd0);

    // Cache miss for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("miss_waiting", {31'h0, bus.i_waiting}, 32'd1);
      chk("miss_addr", bus.i_addr, 32'h210);
      chk("miss_valid", {31'h0, bus.inst_valid}, 32'd0);
    end
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    chk("miss_done_valid", {31'h0, bus.inst_valid}, 32'd1);
    chk("miss_done_pc", bus.inst_pc, 32'h210);
    chk("miss_done_next", bus.i_addr, 32'h214);
    tick(1);
    chk("miss_single_push", {31'h0, bus.inst_valid}, 32'd0);

    // Flush with three queued entries and i_ready high
    bus.dec_ready = 1'b0;
    redirect(32'h300);
    hit = 1'b1;
    tick(3);
    chk("pre_flush_valid", {31'h0, bus.inst_valid}, 32'd1);
    rob_clear = 1'b1;
    rob_pc    = 32'h100;
    tick(1);
    rob_clear = 1'b0;
    hit       = 1'b0;
    chk("flush_valid", {31'h0, bus.inst_valid}, 32'd0);
    chk("flush_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("flush_addr", bus.i_addr, 32'h100);
    tick(1);
    chk("flush_refetch_waiting", {31'h0, bus.i_waiting}, 32'd1);
    chk("flush_refetch_addr", bus.i_addr, 32'h100);

    // Global stall with i_ready and dec_ready asserted
    hit = 1'b1;
    tick(2);
    rdy_in        = 1'b0;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_waiting", {31'h0, bus.i_waiting}, 32'd1);
      chk("stall_addr", bus.i_addr, 32'h108);
      chk("stall_valid", {31'h0, bus.inst_valid}, 32'd1);
      chk("stall_head_pc", bus.inst_pc, 32'h100);
    end
    rdy_in = 1'b1;
    hit    = 1'b0;
    tick(1);
    chk("unstall_head_pc", bus.inst_pc, 32'h104);
    tick(1);
    chk("unstall_drained", {31'h0, bus.inst_valid}, 32'd0);

    // Asynchronous reset in the middle of a request
    chk("prereset_waiting", {31'h0, bus.i_waiting}, 32'd1);
    rst_in = 1'b0;
    #1;
    chk("async_rst_waiting", {31'h0, bus.i_waiting}, 32'd0);
    chk("async_rst_addr", bus.i_addr, 32'h0);
    chk("async_rst_valid", {31'h0, bus.inst_valid}, 32'd0);
    tick(1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end stage directly upstream of the instruction side of the cache block.
- Owns the fetch PC and issues one word-fetch request at a time over the cache's i_waiting/i_addr/i_ready/i_result handshake.
- Applies a static next-PC prediction and buffers fetched instructions in a small FIFO queue for the decoder.
- On a RoB flush, empties the queue and restarts fetch from the redirect PC.

Parameters:
- QUEUE_DEPTH_BITS, 2, log2 of instruction queue depth (depth 4).
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; all state holds when low
- RoB_clear  input  1  synchronous flush/redirect request
- RoB_new_pc  input  32  redirect target, valid with RoB_clear
- i_waiting  output  1  fetch request to cache
- i_addr  output  32  fetch address; stable while i_waiting is high
- i_result  input  32  fetched word, valid when i_ready is high
- i_ready  input  1  fetch complete (combinational from cache)
- dec_ready  input  1  decoder accepts the head instruction this cycle
- inst_valid  output  1  queue not empty
- inst  output  32  head instruction word
- inst_pc  output  32  PC of head instruction
- inst_pred_taken  output  1  head was predicted to redirect (next PC != pc+4)

Behaviour:

Reset (rst_in low, asynchronous):
- state=IDLE, fetch_pc=RESET_PC, queue count=0, head=tail=0.
- Outputs: i_waiting=0, i_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_pred_taken=0.
- Reset asserted mid-request drops the request immediately. The cache is reset by the same event.

Priority each rising edge: reset > !rdy_in (hold everything) > RoB_clear > normal operation.

State machine (registered state):
- IDLE:
  - i_waiting=0.
  - Go to FETCH when count < depth, evaluated on the registered count.
- FETCH:
  - i_waiting=1 and i_addr=fetch_pc, held constant until i_ready.
  - Entering FETCH only with count < depth reserves the slot, so a push at completion can never overflow.
  - On i_ready:
    - Push {i_result, fetch_pc, pred_taken} at tail.
    - fetch_pc <= pred_next.
    - Stay in FETCH if the post-update count < depth, else go to IDLE.
  - i_waiting never drops while in FETCH except on RoB_clear or reset. This prevents aborting a cache miss.
- i_waiting and i_addr are driven from registers only (no combinational path from i_ready). Back-to-back hits complete one instruction per cycle.

Prediction (combinational on i_result, fetch_pc):
- opcode 1101111 (JAL): pred_next = fetch_pc + sext(J-imm); pred_taken=1.
- opcode 1100011 (branch) with imm[12]=1 (backward): pred_next = fetch_pc + sext(B-imm); pred_taken=1.
- Forward branch, JALR, and all other opcodes: pred_next = fetch_pc + 4; pred_taken=0.
- All additions are 32-bit modulo 2^32; wrap-around is silent.

Queue:
- Circular buffer, depth 2^QUEUE_DEPTH_BITS.
- Head and tail pointers wrap modulo depth; count has QUEUE_DEPTH_BITS+1 bits.
- inst_valid = (count != 0). inst, inst_pc, and inst_pred_taken are read from head.
- Pop when inst_valid && dec_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full because a push only occurs with a slot reserved.
- dec_ready with an empty queue is ignored.
- An instruction pushed at edge N is visible at inst_valid after edge N; there is no bypass to the decoder.

RoB_clear (synchronous, with rdy_in high):
- count=0 and head=tail=0.
- fetch_pc <= RoB_new_pc.
- state <= IDLE, so i_waiting=0 for one cycle. The cache aborts its own access on the same signal.
- Any i_ready in that cycle is discarded; no push occurs.
- No pop occurs in that cycle.
- Next cycle: FETCH with i_addr=RoB_new_pc.

rdy_in low: no push, no pop, no state change. Outputs keep their values.

Test Plan:
- Reset then release: i_addr=0 and i_waiting=1 one cycle after rdy_in. Cache returns 32'h00000013 (addi) -> queue holds pc 0, pred_taken=0, next i_addr=4.
- Fetch at pc 0x10 returns JAL with imm=+0x20 (32'h0200006F) -> inst_pred_taken=1, next i_addr=0x30. Backward branch at 0x40 with imm=-8 -> next i_addr=0x38. Forward branch -> next i_addr=0x44.
- dec_ready=0 with four hits -> count=4, i_waiting drops, state IDLE, fetch_pc held. Then one pop -> FETCH resumes at the next sequential PC.
- Miss: i_ready held low 20 cycles -> i_waiting and i_addr stable throughout, no push. On i_ready, exactly one push.
- RoB_clear with RoB_new_pc=0x100 while in FETCH with 3 queued entries and i_ready high the same cycle -> inst_valid=0 next cycle, no push, then i_addr=0x100.
- rdy_in low for 5 cycles with i_ready high and dec_ready high -> no change in count, pointers, or outputs.
